// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the 7-segment scan multiplexer: the blank code,
// slot phase encoding and the digit-validity / leading-zero helpers.
package seg7_pkg;

  // Nibble that the downstream decoder renders as all segments off.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Widest digit bank the helper functions handle; NUM_DIGITS must not exceed it.
  localparam int MAX_DIGITS = 16;

  // Phase of the current digit slot.
  typedef enum logic [0:0] {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_phase_e;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

  // Per-digit leading-zero blank vector. Digit i is blanked when blanking is
  // enabled, i is not the least significant digit, and every digit from i up
  // to the most significant one is zero. Only the low num_digits digits count.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] bank,
    input logic                    lz_en,
    input int                      num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = '0;
    zero_run = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < num_digits) begin
        zero_run = zero_run & (bank[4*i +: 4] == 4'd0);
        mask[i]  = lz_en & zero_run & (i != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Connection bundle between a digit producer and the scan multiplexer.
// There is no handshake: writes and loads are single-cycle strobes that are
// always accepted, and the display outputs are free-running registered values.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  // Shadow-bank update side
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [3:0]              wr_data;
  logic                    load_all;
  logic [4*NUM_DIGITS-1:0] all_data;
  logic                    lz_blank_en;

  // Display side
  logic [3:0]              digit_bcd;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic                    frame_tick;

  // Producer / test driver
  modport master (
    output wr_en, wr_addr, wr_data, load_all, all_data, lz_blank_en,
    input  digit_bcd, digit_en_n, frame_tick
  );

  // Scan multiplexer
  modport slave (
    input  wr_en, wr_addr, wr_data, load_all, all_data, lz_blank_en,
    output digit_bcd, digit_en_n, frame_tick
  );

endinterface

// File: rtl/seg7_refresh_timer.sv
// Slot timing for the scanner: a prescaler that defines one digit slot and a
// slot index that walks the digits. Reports the slot phase and the frame wrap.
module seg7_refresh_timer
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_DIGITS   = 4,
  localparam int AW          = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] idx,
  output logic          show_phase,
  output logic          frame_wrap,
  output slot_phase_e   phase
);

  localparam int PW = $clog2(REFRESH_DIV);

  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [AW-1:0] I_LAST  = AW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q;
  logic [AW-1:0] idx_q;
  logic          slot_wrap;

  assign slot_wrap = (presc_q == P_LAST);

  // Prescaler counts through one slot; the slot index advances at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (slot_wrap) begin
      presc_q <= '0;
      idx_q   <= (idx_q == I_LAST) ? '0 : idx_q + AW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // The first BLANK_CYCLES of every slot keep all anodes off to stop ghosting.
  always_comb begin
    show_phase = (presc_q >= P_BLANK);
    phase      = show_phase ? SLOT_SHOW : SLOT_BLANK;
  end

  assign idx        = idx_q;
  assign frame_wrap = slot_wrap && (idx_q == I_LAST);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a common-anode 7-segment bank. Digits are
// written into a shadow bank and copied to the display bank only at the frame
// wrap, so a frame never shows a mix of old and new digits.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int AW          = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_mux_if.slave   bus
);

  localparam int BW = 4 * NUM_DIGITS;

  logic [BW-1:0]           shadow_q;
  logic [BW-1:0]           shadow_d;
  logic [BW-1:0]           display_q;

  logic [AW-1:0]           idx;
  logic                    show_phase;
  logic                    frame_wrap;
  slot_phase_e             phase;

  logic [4*MAX_DIGITS-1:0] display_pad;
  logic [MAX_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_nibble;
  logic [3:0]              shown;
  logic [3:0]              bcd_d;
  logic [NUM_DIGITS-1:0]   en_n_d;

  seg7_refresh_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .NUM_DIGITS   (NUM_DIGITS)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx),
    .show_phase (show_phase),
    .frame_wrap (frame_wrap),
    .phase      (phase)
  );

  // Next shadow contents: a bulk load wins over a single-digit write, and a
  // write to a digit that does not exist is ignored.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.load_all) begin
      shadow_d = bus.all_data;
    end else if (bus.wr_en && (int'(bus.wr_addr) < NUM_DIGITS)) begin
      shadow_d[4*int'(bus.wr_addr) +: 4] = bus.wr_data;
    end
  end

  // Shadow follows every update; the display bank takes the next-shadow value
  // at the frame wrap so a write landing on that very cycle is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      display_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (frame_wrap) begin
        display_q <= shadow_d;
      end
    end
  end

  // Select what the current digit shows: non-decimal nibbles and leading
  // zeros become the blank code. Blanking enable is used live, not committed.
  always_comb begin
    display_pad             = '0;
    display_pad[BW-1:0]     = display_q;
    blank_vec               = lz_mask(display_pad, bus.lz_blank_en, NUM_DIGITS);
    cur_nibble              = display_q[4*int'(idx) +: 4];
    if (!is_bcd(cur_nibble)) begin
      shown = BCD_BLANK;
    end else if (blank_vec[idx]) begin
      shown = BCD_BLANK;
    end else begin
      shown = cur_nibble;
    end
  end

  // Anode and nibble values for the current slot phase.
  always_comb begin
    en_n_d = '1;
    bcd_d  = BCD_BLANK;
    if (phase == SLOT_SHOW) begin
      en_n_d[idx] = 1'b0;
      bcd_d       = shown;
    end
  end

  // Registered outputs, one cycle behind the timer; reset forces all off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.digit_en_n <= '1;
      bus.digit_bcd  <= BCD_BLANK;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.digit_en_n <= en_n_d;
      bus.digit_bcd  <= bcd_d;
      bus.frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with 4 digits, 8-cycle slots and 2 blank cycles.
// The stimulus pushes the expected per-slot output for each frame; the
// monitor pops one entry at the start of each slot's show phase.
module tb_seg7_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  typedef enum int {OP_NONE, OP_LOAD, OP_WR, OP_BOTH} op_e;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_mux #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         checks     = 0;
  int         failures   = 0;
  int         cyc;
  int         last_tick  = 0;
  int         tick_count = 0;
  logic       have_hold  = 1'b0;
  logic [7:0] hold       = 8'h00;

  // Clock edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    int pos;
    if (!rst_n) begin
      check("reset_en_n", 32'(bus.digit_en_n), 32'hF);
      check("reset_bcd",  32'(bus.digit_bcd),  32'hF);
      check("reset_tick", 32'(bus.frame_tick), 32'h0);
      last_tick = 0;
      have_hold = 1'b0;
    end else begin
      if (bus.frame_tick) begin
        check("tick_period", 32'(cyc - last_tick), 32'(FRAME));
        last_tick = cyc;
        tick_count++;
      end
      pos = (cyc == 0) ? 0 : (cyc - 1) % DIV;
      if (cyc == 0 || pos < BLANK) begin
        check("blank_en_n", 32'(bus.digit_en_n), 32'hF);
        check("blank_bcd",  32'(bus.digit_bcd),  32'hF);
      end else begin
        if (pos == BLANK) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL queue_empty: slot output en_n=%b bcd=%h with nothing expected (cyc %0d)",
                     bus.digit_en_n, bus.digit_bcd, cyc);
            have_hold = 1'b0;
          end else begin
            hold      = exp_q.pop_front();
            have_hold = 1'b1;
          end
        end
        if (have_hold) begin
          check("slot_en_n", 32'(bus.digit_en_n), 32'(hold[7:4]));
          check("slot_bcd",  32'(bus.digit_bcd),  32'(hold[3:0]));
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [15:0] exp_digits);
    for (int i = 0; i < N; i++) begin
      logic [3:0] en;
      en    = 4'hF;
      en[i] = 1'b0;
      exp_q.push_back({en, exp_digits[4*i +: 4]});
    end
  endtask

  task automatic apply_op(input op_e op, input logic [15:0] data,
                          input logic [1:0] addr, input logic [3:0] wdata);
    bus.load_all = (op == OP_LOAD) || (op == OP_BOTH);
    bus.all_data = data;
    bus.wr_en    = (op == OP_WR) || (op == OP_BOTH);
    bus.wr_addr  = addr;
    bus.wr_data  = wdata;
  endtask

  // One full frame: expected shown digits (d3..d0), live blanking enable, and
  // an optional update either mid-frame or on the commit cycle.
  task automatic run_frame(input logic [15:0] exp_digits, input logic lz, input op_e op,
                           input logic at_commit, input logic [15:0] data,
                           input logic [1:0] addr, input logic [3:0] wdata);
    push_frame(exp_digits);
    bus.lz_blank_en = lz;
    if (op == OP_NONE) begin
      step(FRAME);
    end else if (at_commit) begin
      step(FRAME - 1);
      apply_op(op, data, addr, wdata);
      step(1);
      apply_op(OP_NONE, 16'h0, 2'd0, 4'h0);
    end else begin
      step(9);
      apply_op(op, data, addr, wdata);
      step(1);
      apply_op(OP_NONE, 16'h0, 2'd0, 4'h0);
      step(FRAME - 10);
    end
  endtask

  // Stimulus
  initial begin
    rst_n           = 1'b1;
    bus.lz_blank_en = 1'b0;
    apply_op(OP_NONE, 16'h0, 2'd0, 4'h0);
    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    //        shown    lz    op       commit data      addr  wdata
    run_frame(16'h0000, 1'b0, OP_LOAD, 1'b0, 16'h1234, 2'd0, 4'h0);
    run_frame(16'h1234, 1'b0, OP_WR,   1'b1, 16'h0000, 2'd2, 4'h9);
    run_frame(16'h1934, 1'b0, OP_BOTH, 1'b1, 16'h5678, 2'd0, 4'h1);
    run_frame(16'h5678, 1'b0, OP_LOAD, 1'b0, 16'h0070, 2'd0, 4'h0);
    run_frame(16'hFF70, 1'b1, OP_NONE, 1'b0, 16'h0000, 2'd0, 4'h0);
    run_frame(16'h0070, 1'b0, OP_LOAD, 1'b0, 16'h0000, 2'd0, 4'h0);
    run_frame(16'hFFF0, 1'b1, OP_WR,   1'b0, 16'h0000, 2'd1, 4'hB);
    run_frame(16'h00F0, 1'b0, OP_WR,   1'b0, 16'h0000, 2'd3, 4'hC);
    run_frame(16'hF0F0, 1'b1, OP_BOTH, 1'b0, 16'h0305, 2'd1, 4'h8);
    run_frame(16'hF305, 1'b1, OP_NONE, 1'b0, 16'h0000, 2'd0, 4'h0);

    // Partial frame, then reset while slot 2 is being shown
    push_frame(16'hF305);
    bus.lz_blank_en = 1'b1;
    step(2 * DIV + 6);
    check("pre_reset_en_n", 32'(bus.digit_en_n), 32'hB);
    rst_n = 1'b0;
    #1;
    check("midreset_en_n", 32'(bus.digit_en_n), 32'hF);
    check("midreset_bcd",  32'(bus.digit_bcd),  32'hF);
    exp_q.delete();
    step(3);
    rst_n = 1'b1;

    run_frame(16'h0000, 1'b0, OP_NONE, 1'b0, 16'h0000, 2'd0, 4'h0);
    run_frame(16'hFFF0, 1'b1, OP_NONE, 1'b0, 16'h0000, 2'd0, 4'h0);

    @(negedge clk);
    #1;
    check("tick_count", 32'(tick_count), 32'd12);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
